instruction_cache: RTL and testbench

//   Direct-mapped, one-word-per-line instruction cache between the CPU ROM port (chip_enable/address/data)
//   and a slower external instruction memory with a read request/ready handshake.

---
 rtl/instruction_cache_pkg.sv | 16 +
 rtl/instruction_cache_array.sv | 56 +++++
 rtl/instruction_cache.sv | 146 ++++++++++++++
 tb/tb_instruction_cache.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared cache definitions: FSM state encoding, default geometry and address field widths.
// Optional statistics counters are enabled with the INSTRUCTION_CACHE_STATS_EN macro.
package instruction_cache_pkg;

    typedef enum logic {
        CACHE_STATE_IDLE   = 1'b0,
        CACHE_STATE_REFILL = 1'b1
    } cache_state_e;

    localparam int unsigned DEFAULT_LINE_COUNT  = 64;
    localparam int unsigned DEFAULT_INDEX_WIDTH = 6;
    localparam int unsigned WORD_OFFSET_WIDTH   = 2;
    localparam int unsigned ADDR_WIDTH          = 32;
    localparam int unsigned DATA_WIDTH          = 32;

endpackage

// File: rtl/instruction_cache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read port, one synchronous write port and a synchronous clear of all valid bits.
module instruction_cache_array
    import instruction_cache_pkg::*;
#(
    parameter int unsigned LINE_COUNT  = DEFAULT_LINE_COUNT,
    parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int unsigned TAG_WIDTH   = ADDR_WIDTH - WORD_OFFSET_WIDTH - DEFAULT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   clear_all
);

    logic [LINE_COUNT-1:0] valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_mem  [LINE_COUNT];
    logic [DATA_WIDTH-1:0] data_mem [LINE_COUNT];

    // A clear in the same cycle as a write leaves the freshly written line invalid.
    always_comb begin
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache with a single-word refill handshake.
// Define INSTRUCTION_CACHE_STATS_EN to add hit_count/miss_count outputs.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int unsigned LINE_COUNT  = DEFAULT_LINE_COUNT,
    parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chip_enable,
    input  logic [31:0] address,
    output logic [31:0] data,
    output logic        stall,
    input  logic        invalidate,
    output logic        memory_read_enable,
    output logic [31:0] memory_address,
    input  logic [31:0] memory_data,
    input  logic        memory_ready
`ifdef INSTRUCTION_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned TAG_LSB   = INDEX_WIDTH + WORD_OFFSET_WIDTH;
    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - TAG_LSB;

    cache_state_e           state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [INDEX_WIDTH-1:0] lookup_index, refill_index;
    logic [TAG_WIDTH-1:0]   lookup_tag, refill_tag, line_tag;
    logic                   line_valid;
    logic [31:0]            line_data;
    logic                   hit, idle_lookup, refill_done;
    logic                   unused_addr_bits;

    assign lookup_index     = address[TAG_LSB-1:WORD_OFFSET_WIDTH];
    assign lookup_tag       = address[ADDR_WIDTH-1:TAG_LSB];
    assign refill_index     = mem_addr_q[TAG_LSB-1:WORD_OFFSET_WIDTH];
    assign refill_tag       = mem_addr_q[ADDR_WIDTH-1:TAG_LSB];
    assign unused_addr_bits = ^address[WORD_OFFSET_WIDTH-1:0];

    assign hit         = line_valid && (line_tag == lookup_tag);
    assign idle_lookup = (state_q == CACHE_STATE_IDLE) && chip_enable;
    // Refill writes go to the latched address, so a CPU address change mid-refill is harmless.
    assign refill_done = (state_q == CACHE_STATE_REFILL) && memory_ready;

    instruction_cache_array #(
        .LINE_COUNT  (LINE_COUNT),
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .rd_index  (lookup_index),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_en     (refill_done),
        .wr_index  (refill_index),
        .wr_tag    (refill_tag),
        .wr_data   (memory_data),
        .clear_all (invalidate)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= CACHE_STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CACHE_STATE_IDLE:   if (chip_enable && !hit) state_d = CACHE_STATE_REFILL;
            CACHE_STATE_REFILL: if (memory_ready) state_d = CACHE_STATE_IDLE;
        endcase
    end

    // CPU-side outputs are combinational; the memory request is registered from the next state.
    always_comb begin
        data       = '0;
        stall      = 1'b0;
        mem_req_d  = (state_d == CACHE_STATE_REFILL);
        mem_addr_d = mem_addr_q;
        case (state_q)
            CACHE_STATE_IDLE: begin
                if (chip_enable) begin
                    if (hit) begin
                        data = line_data;
                    end else begin
                        stall      = 1'b1;
                        mem_addr_d = {address[ADDR_WIDTH-1:WORD_OFFSET_WIDTH], WORD_OFFSET_WIDTH'(0)};
                    end
                end
            end
            CACHE_STATE_REFILL: stall = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign memory_read_enable = mem_req_q;
    assign memory_address     = mem_addr_q;

`ifdef INSTRUCTION_CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Counters wrap naturally and are untouched by invalidate.
    always_comb begin
        hit_count_d  = hit_count_q + 32'(idle_lookup && hit);
        miss_count_d = miss_count_q + 32'(idle_lookup && !hit);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_idle_lookup;
    assign unused_idle_lookup = idle_lookup;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed vector table, multi-cycle corner sequences
// and randomized fetches checked against a line-array model of the cache.
module tb_instruction_cache;

    logic        clock = 1'b0;
    logic        reset;
    logic        chip_enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        stall;
    logic        invalidate;
    logic        memory_read_enable;
    logic [31:0] memory_address;
    logic [31:0] memory_data;
    logic        memory_ready;
`ifdef INSTRUCTION_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;
    int mem_latency = 0;
    int req_age = 0;

    bit          model_valid [64];
    logic [23:0] model_tag   [64];

    typedef struct {
        logic [31:0] addr;
        int          lat;
        bit          exp_hit;
        string       name;
    } vec_t;

    vec_t vecs [12];

    always #5 clock = ~clock;

    instruction_cache dut (
        .clock              (clock),
        .reset              (reset),
        .chip_enable        (chip_enable),
        .address            (address),
        .data               (data),
        .stall              (stall),
        .invalidate         (invalidate),
        .memory_read_enable (memory_read_enable),
        .memory_address     (memory_address),
        .memory_data        (memory_data),
        .memory_ready       (memory_ready)
`ifdef INSTRUCTION_CACHE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (wa == 32'h0000_0040) return 32'h2401_0005;
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return model_valid[a[7:2]] && (model_tag[a[7:2]] == a[31:8]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [31:0] a);
        model_valid[a[7:2]] = 1'b1;
        model_tag[a[7:2]]   = a[31:8];
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Advance one clock; the memory answers mem_latency cycles after it first sees the request.
    task automatic cycle();
        @(posedge clock);
        #1;
        if (memory_read_enable) req_age++;
        else req_age = 0;
        memory_ready = memory_read_enable && (req_age == mem_latency + 1);
        memory_data  = memory_ready ? mem_word(memory_address) : 32'h0BAD_0BAD;
    endtask

    task automatic wait_unstall(input string nm);
        int n = 0;
        while (stall && n < 60) begin
            cycle();
            n++;
        end
        check({nm, " unstall"}, 32'(stall), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] a, input int lat, input bit exp_hit, input string nm);
        logic [31:0] wa;
        int stalls;
        wa = {a[31:2], 2'b00};
        stalls = 0;
        mem_latency = lat;
        chip_enable = 1'b1;
        address = a;
        #1;
        while (stall && stalls < 60) begin
            if (stalls == 0) check({nm, " data during miss"}, data, 32'd0);
            if (stalls == 1) begin
                check({nm, " mem req"}, 32'(memory_read_enable), 32'd1);
                check({nm, " mem addr"}, memory_address, wa);
            end
            cycle();
            stalls++;
        end
        check({nm, " stall cycles"}, 32'(stalls), exp_hit ? 32'd0 : 32'(2 + lat));
        check({nm, " data"}, data, mem_word(wa));
        check({nm, " no req on hit"}, 32'(memory_read_enable), 32'd0);
        if (!exp_hit) model_fill(a);
        cycle();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        chip_enable = 1'b0;
        invalidate = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        model_clear();
    endtask

    initial begin
        int n;
        logic [31:0] a;
        reset = 1'b0;
        chip_enable = 1'b0;
        address = '0;
        invalidate = 1'b0;
        memory_ready = 1'b0;
        memory_data = '0;
        model_clear();
        #2;
        check("reset mem req", 32'(memory_read_enable), 32'd0);
        check("reset mem addr", memory_address, 32'd0);
        check("reset data", data, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
`ifdef INSTRUCTION_CACHE_STATS_EN
        check("reset hit_count", hit_count, 32'd0);
        check("reset miss_count", miss_count, 32'd0);
`endif
        cycle();
        cycle();
        reset = 1'b1;
        cycle();

        // Index = addr[7:2], tag = addr[31:8]; 0x140 shares line 16 with 0x40.
        vecs[0]  = '{32'h0000_0040, 3, 1'b0, "cold"};
        vecs[1]  = '{32'h0000_0040, 0, 1'b1, "hit1"};
        vecs[2]  = '{32'h0000_0040, 0, 1'b1, "hit2"};
        vecs[3]  = '{32'h0000_0044, 0, 1'b0, "neighbour"};
        vecs[4]  = '{32'h0000_0140, 1, 1'b0, "alias"};
        vecs[5]  = '{32'h0000_0040, 2, 1'b0, "evicted"};
        vecs[6]  = '{32'h0000_0044, 0, 1'b1, "neighbour hit"};
        vecs[7]  = '{32'h0000_0100, 0, 1'b0, "index0"};
        vecs[8]  = '{32'h0000_0040, 0, 1'b1, "hit3"};
        vecs[9]  = '{32'hFFFF_FFFC, 1, 1'b0, "top"};
        vecs[10] = '{32'hFFFF_FFFF, 0, 1'b1, "byte offset"};
        vecs[11] = '{32'h0000_0100, 0, 1'b1, "index0 hit"};
        for (int i = 0; i < 12; i++) do_fetch(vecs[i].addr, vecs[i].lat, vecs[i].exp_hit, vecs[i].name);

        // Invalidate on the refill completion edge: the line stays invalid.
        mem_latency = 2;
        chip_enable = 1'b1;
        address = 32'h0000_0080;
        #1;
        check("inv_edge first miss", 32'(stall), 32'd1);
        n = 0;
        while (!memory_ready && n < 20) begin
            cycle();
            n++;
        end
        invalidate = 1'b1;
        cycle();
        invalidate = 1'b0;
        #1;
        check("inv_edge re-miss", 32'(stall), 32'd1);
        cycle();
        check("inv_edge re-request", 32'(memory_read_enable), 32'd1);
        wait_unstall("inv_edge");
        check("inv_edge data", data, mem_word(32'h0000_0080));
        model_clear();
        model_fill(32'h0000_0080);
        cycle();

        // Invalidate in IDLE: same-cycle lookup still hits, the next one misses.
        mem_latency = 1;
        address = 32'h0000_0080;
        invalidate = 1'b1;
        #1;
        check("inv_idle same-cycle stall", 32'(stall), 32'd0);
        check("inv_idle same-cycle data", data, mem_word(32'h0000_0080));
        cycle();
        invalidate = 1'b0;
        #1;
        check("inv_idle next miss", 32'(stall), 32'd1);
        wait_unstall("inv_idle");
        check("inv_idle refill data", data, mem_word(32'h0000_0080));
        model_clear();
        model_fill(32'h0000_0080);
        cycle();

        // Invalidate mid-refill without ready: refill still completes and is valid.
        mem_latency = 4;
        address = 32'h0000_00C0;
        #1;
        cycle();
        cycle();
        invalidate = 1'b1;
        cycle();
        invalidate = 1'b0;
        wait_unstall("inv_refill");
        check("inv_refill data", data, mem_word(32'h0000_00C0));
        model_clear();
        model_fill(32'h0000_00C0);
        cycle();
        do_fetch(32'h0000_00C0, 0, 1'b1, "inv_refill kept");
        do_fetch(32'h0000_0080, 1, 1'b0, "inv_refill cleared");

        // A stray memory_ready in IDLE must not disturb the line at the latched address.
        chip_enable = 1'b0;
        memory_ready = 1'b1;
        memory_data = 32'hDEAD_BEEF;
        cycle();
        do_fetch(32'h0000_0080, 0, 1'b1, "stray ready");

        // Reset while waiting on memory_ready.
        mem_latency = 6;
        chip_enable = 1'b1;
        address = 32'h0000_0200;
        #1;
        cycle();
        cycle();
        check("rst_refill req before", 32'(memory_read_enable), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_refill req dropped", 32'(memory_read_enable), 32'd0);
        check("rst_refill addr cleared", memory_address, 32'd0);
        memory_ready = 1'b1;
        memory_data = 32'hDEAD_BEEF;
        cycle();
        cycle();
        reset = 1'b1;
        model_clear();
        do_fetch(32'h0000_0200, 1, 1'b0, "after reset");
        do_fetch(32'h0000_0080, 0, 1'b0, "after reset cleared");

        // Randomized fetches, idle cycles and invalidates against the model.
        for (int t = 0; t < 150; t++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                chip_enable = 1'b0;
                address = $urandom;
                #1;
                check("rand idle data", data, 32'd0);
                check("rand idle stall", 32'(stall), 32'd0);
                cycle();
            end else if (op == 1) begin
                chip_enable = 1'b0;
                invalidate = 1'b1;
                cycle();
                invalidate = 1'b0;
                model_clear();
            end else begin
                case ($urandom_range(0, 3))
                    0: a[7:2] = 6'd0;
                    1: a[7:2] = 6'd1;
                    2: a[7:2] = 6'd16;
                    default: a[7:2] = 6'd63;
                endcase
                a[31:8] = 24'($urandom_range(0, 2));
                a[1:0]  = 2'($urandom_range(0, 3));
                do_fetch(a, int'($urandom_range(0, 4)), model_hit(a), "rand fetch");
            end
        end

`ifdef INSTRUCTION_CACHE_STATS_EN
        // One miss (its final serving cycle counts as a hit) plus three more hits.
        apply_reset();
        check("stats reset hit", hit_count, 32'd0);
        check("stats reset miss", miss_count, 32'd0);
        do_fetch(32'h0000_0040, 3, 1'b0, "stats miss");
        for (int i = 0; i < 3; i++) do_fetch(32'h0000_0040, 0, 1'b1, "stats hit");
        check("stats miss_count", miss_count, 32'd1);
        check("stats hit_count", hit_count, 32'd4);
        chip_enable = 1'b0;
        invalidate = 1'b1;
        cycle();
        invalidate = 1'b0;
        check("stats kept miss", miss_count, 32'd1);
        check("stats kept hit", hit_count, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
